// File: rtl/tiny16_mem_pkg.sv
// Shared types and constants for the tiny16 memory/bus controller and its address decoder.
package tiny16_mem_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned IO_ADDR_W = 8;
    localparam int unsigned WAIT_W    = 3;

    localparam logic [ADDR_W-1:0] ROM_TOP_DEF  = 16'h0FFF;
    localparam logic [ADDR_W-1:0] IO_BASE_DEF  = 16'hFF00;
    localparam logic [DATA_W-1:0] IO_TMO_RDATA = 16'hFFFF;

    typedef enum logic [1:0] {
        REG_ROM,
        REG_RAM,
        REG_IO
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_IO_WAIT,
        ST_DONE
    } state_e;

    // Request captured at the start of a multi-cycle transfer.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wr;
        region_e           region;
    } bus_req_t;

endpackage

// File: rtl/tiny16_addr_decode.sv
// Combinational address-to-region decoder: ROM at the bottom, I/O at the top, RAM between.
module tiny16_addr_decode
    import tiny16_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_TOP = ROM_TOP_DEF,
    parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
    input  logic [ADDR_W-1:0] addr_i,
    output region_e           region_o
);

    always_comb begin
        region_o = REG_RAM;
        if (addr_i <= ROM_TOP) begin
            region_o = REG_ROM;
        end else if (addr_i >= IO_BASE) begin
            region_o = REG_IO;
        end
    end

endmodule

// File: rtl/tiny16_mem_ctrl.sv
// tiny16 memory/bus controller: region decode, wait states, I/O handshake, sticky bus error.
// Optional I/O ack timeout enabled by defining TINY16_MEM_CTRL_IO_TIMEOUT_EN.
module tiny16_mem_ctrl
    import tiny16_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ROM_TOP    = ROM_TOP_DEF,
    parameter logic [ADDR_W-1:0] IO_BASE    = IO_BASE_DEF,
    parameter int unsigned       ROM_WAIT   = 1,
    parameter int unsigned       RAM_WAIT   = 0,
    parameter int unsigned       IO_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    cpu_address,
    input  logic [DATA_W-1:0]    cpu_wdata,
    input  logic                 cpu_rd_n,
    input  logic                 cpu_wr,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ready,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [DATA_W-1:0]    rom_data,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    output logic                 ram_we,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic [IO_ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0]    io_wdata,
    output logic                 io_rd,
    output logic                 io_wr,
    input  logic [DATA_W-1:0]    io_rdata,
    input  logic                 io_ack,
    output logic                 bus_error
);

    localparam logic [WAIT_W-1:0] ROM_N = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_N = WAIT_W'(RAM_WAIT);

    if (ROM_WAIT > 7 || RAM_WAIT > 7 || IO_TIMEOUT == 0) begin : g_bad_cfg
        $error("tiny16_mem_ctrl: wait states must be 0..7 and IO_TIMEOUT nonzero");
    end

    region_e           cur_region;
    logic              req;
    logic [WAIT_W-1:0] cur_wait;

    state_e            state_q, state_d;
    bus_req_t          lat_q, lat_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] io_data_q, io_data_d;
    logic              bus_error_q, bus_error_d;
    logic              io_rd_q, io_rd_d;
    logic              io_wr_q, io_wr_d;

`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(IO_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(IO_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    tiny16_addr_decode #(
        .ROM_TOP (ROM_TOP),
        .IO_BASE (IO_BASE)
    ) u_addr_decode (
        .addr_i   (cpu_address),
        .region_o (cur_region)
    );

    assign req      = !cpu_rd_n || cpu_wr;
    assign cur_wait = (cur_region == REG_ROM) ? ROM_N : RAM_N;

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            cnt_q       <= '0;
            io_data_q   <= '0;
            bus_error_q <= 1'b0;
            io_rd_q     <= 1'b0;
            io_wr_q     <= 1'b0;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            cnt_q       <= cnt_d;
            io_data_q   <= io_data_d;
            bus_error_q <= bus_error_d;
            io_rd_q     <= io_rd_d;
            io_wr_q     <= io_wr_d;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    // Next-state and bus outputs
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        cnt_d       = cnt_q;
        io_data_d   = io_data_q;
        bus_error_d = bus_error_q;
        io_rd_d     = io_rd_q;
        io_wr_d     = io_wr_q;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        ram_we      = 1'b0;
        rom_addr    = lat_q.addr;
        ram_addr    = lat_q.addr;
        ram_wdata   = lat_q.wdata;

        unique case (state_q)
            ST_IDLE: begin
                rom_addr  = cpu_address;
                ram_addr  = cpu_address;
                ram_wdata = cpu_wdata;
                cpu_ready = 1'b1;
                if (req) begin
                    if ((!cpu_rd_n && cpu_wr) || (cpu_wr && cur_region == REG_ROM)) begin
                        bus_error_d = 1'b1;
                    end
                    lat_d.addr   = cpu_address;
                    lat_d.wdata  = cpu_wdata;
                    lat_d.wr     = cpu_wr;
                    lat_d.region = cur_region;
                    if (cur_region == REG_IO) begin
                        cpu_ready = 1'b0;
                        io_rd_d   = !cpu_wr;
                        io_wr_d   = cpu_wr;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
                        tmo_d     = '0;
`endif
                        state_d   = ST_IO_WAIT;
                    end else if (cur_wait == '0) begin
                        ram_we = cpu_wr && (cur_region == REG_RAM);
                        if (!cpu_wr) begin
                            cpu_rdata = (cur_region == REG_ROM) ? rom_data : ram_rdata;
                        end
                    end else begin
                        // The IDLE cycle counts as the first of the N ready-low cycles.
                        cpu_ready = 1'b0;
                        cnt_d     = cur_wait - WAIT_W'(1);
                        state_d   = (cur_wait == WAIT_W'(1)) ? ST_DONE : ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - WAIT_W'(1);
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_IO_WAIT: begin
                if (io_ack) begin
                    io_data_d = io_rdata;
                    io_rd_d   = 1'b0;
                    io_wr_d   = 1'b0;
                    state_d   = ST_DONE;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    io_data_d   = IO_TMO_RDATA;
                    io_rd_d     = 1'b0;
                    io_wr_d     = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            ST_DONE: begin
                cpu_ready = 1'b1;
                state_d   = ST_IDLE;
                if (lat_q.wr) begin
                    ram_we = (lat_q.region == REG_RAM);
                end else begin
                    unique case (lat_q.region)
                        REG_ROM: cpu_rdata = rom_data;
                        REG_RAM: cpu_rdata = ram_rdata;
                        default: cpu_rdata = io_data_q;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // While reset is held the bus must look idle.
        if (!reset) begin
            cpu_ready = 1'b1;
            ram_we    = 1'b0;
        end
    end

    assign io_addr   = lat_q.addr[IO_ADDR_W-1:0];
    assign io_wdata  = lat_q.wdata;
    assign io_rd     = io_rd_q;
    assign io_wr     = io_wr_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_tiny16_mem_ctrl.sv
// Directed self-checking bench for tiny16_mem_ctrl (ROM_WAIT=3, RAM_WAIT=0).
module tb_tiny16_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic        cpu_rd_n;
    logic        cpu_wr;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_rd;
    logic        io_wr;
    logic [15:0] io_rdata;
    logic        io_ack;
    logic        bus_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // ROM contents are a function of the address so read data is predictable.
    assign rom_data = {4'hA, rom_addr[11:0]};

    tiny16_mem_ctrl #(
        .ROM_WAIT (3),
        .RAM_WAIT (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_wr      (cpu_wr),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .io_addr     (io_addr),
        .io_wdata    (io_wdata),
        .io_rd       (io_rd),
        .io_wr       (io_wr),
        .io_rdata    (io_rdata),
        .io_ack      (io_ack),
        .bus_error   (bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cpu_rd_n = 1'b1;
        cpu_wr   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo;
        int n;
        logic strobe_seen;

        reset = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_rd_n = 1'b1; cpu_wr = 1'b0;
        ram_rdata = '0; io_rdata = '0; io_ack = 1'b0;
        tick(); tick();
        chk("rst_ready", cpu_ready, 1);
        chk("rst_berr", bus_error, 0);
        chk("rst_iord", io_rd, 0);
        chk("rst_iowr", io_wr, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_rdata", cpu_rdata, 0);
        reset = 1'b1;
        tick();

        // zero-wait RAM read
        cpu_address = 16'h2000; cpu_rd_n = 1'b0; ram_rdata = 16'hBEEF;
        #1;
        chk("ram_rd_ready", cpu_ready, 1);
        chk("ram_rd_data", cpu_rdata, 16'hBEEF);
        chk("ram_rd_addr", ram_addr, 16'h2000);
        tick();
        bus_idle(); ram_rdata = '0;
        #1;
        chk("ram_rd_after_ready", cpu_ready, 1);
        chk("ram_rd_after_data", cpu_rdata, 0);

        // ROM read with 3 wait states
        cpu_address = 16'h0010; cpu_rd_n = 1'b0;
        lo = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cpu_ready) break;
            lo++;
            tick();
        end
        chk("rom_rd_low_cycles", lo, 3);
        chk("rom_rd_done_data", cpu_rdata, 16'hA010);
        chk("rom_rd_done_addr", rom_addr, 16'h0010);
        tick();
        bus_idle();
        #1;
        chk("rom_rd_idle_ready", cpu_ready, 1);
        chk("rom_rd_idle_data", cpu_rdata, 0);

        // zero-wait RAM write
        cpu_address = 16'h2004; cpu_wdata = 16'h1234; cpu_wr = 1'b1;
        #1;
        chk("ram_wr_we", ram_we, 1);
        chk("ram_wr_addr", ram_addr, 16'h2004);
        chk("ram_wr_wdata", ram_wdata, 16'h1234);
        chk("ram_wr_ready", cpu_ready, 1);
        tick();
        bus_idle();
        #1;
        chk("ram_wr_we_pulse", ram_we, 0);
        chk("ram_wr_berr", bus_error, 0);

        // ROM write: no strobe, sticky error
        cpu_address = 16'h0004; cpu_wdata = 16'h5A5A; cpu_wr = 1'b1;
        strobe_seen = 1'b0; lo = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            strobe_seen = strobe_seen | ram_we | io_wr;
            if (cpu_ready) break;
            lo++;
            tick();
        end
        chk("rom_wr_low_cycles", lo, 3);
        chk("rom_wr_no_strobe", strobe_seen, 0);
        chk("rom_wr_berr", bus_error, 1);
        tick();
        bus_idle();
        for (int i = 0; i < 5; i++) tick();
        chk("rom_wr_berr_sticky", bus_error, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rom_wr_berr_clear", bus_error, 0);

        // I/O read with ack in the fifth strobe cycle
        cpu_address = 16'hFF05; cpu_rd_n = 1'b0;
        #1;
        chk("io_rd_idle_ready", cpu_ready, 0);
        chk("io_rd_idle_strobe", io_rd, 0);
        tick();
        bus_idle();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (io_rd && io_addr == 8'h05 && !cpu_ready) n++;
            tick();
        end
        io_ack = 1'b1; io_rdata = 16'h00A5;
        #1;
        if (io_rd) n++;
        chk("io_rd_strobe_cycles", n, 5);
        tick();
        io_ack = 1'b0; io_rdata = 16'h0000;
        #1;
        chk("io_rd_done_strobe", io_rd, 0);
        chk("io_rd_done_ready", cpu_ready, 1);
        chk("io_rd_done_data", cpu_rdata, 16'h00A5);
        tick();
        chk("io_rd_idle_data", cpu_rdata, 0);

        // I/O write with ack after one strobe cycle
        cpu_address = 16'hFF10; cpu_wdata = 16'h5555; cpu_wr = 1'b1;
        tick();
        bus_idle();
        chk("io_wr_strobe", io_wr, 1);
        chk("io_wr_addr", io_addr, 8'h10);
        chk("io_wr_wdata", io_wdata, 16'h5555);
        chk("io_wr_no_rd", io_rd, 0);
        io_ack = 1'b1;
        tick();
        io_ack = 1'b0;
        #1;
        chk("io_wr_done_strobe", io_wr, 0);
        chk("io_wr_done_ready", cpu_ready, 1);
        chk("io_wr_done_we", ram_we, 0);
        tick();

        // read and write together: write wins, error raised
        cpu_address = 16'h3000; cpu_wdata = 16'h7777; cpu_rd_n = 1'b0; cpu_wr = 1'b1;
        ram_rdata = 16'h1111;
        #1;
        chk("both_we", ram_we, 1);
        chk("both_rdata", cpu_rdata, 0);
        chk("both_wdata", ram_wdata, 16'h7777);
        tick();
        bus_idle();
        #1;
        chk("both_berr", bus_error, 1);

        // reset while waiting on I/O
        cpu_address = 16'hFF20; cpu_rd_n = 1'b0;
        tick();
        bus_idle();
        tick();
        chk("rstio_strobe_before", io_rd, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rstio_strobe", io_rd, 0);
        chk("rstio_ready", cpu_ready, 1);
        chk("rstio_berr", bus_error, 0);
        tick(); tick();
        chk("rstio_strobe_later", io_rd, 0);

        // I/O read with no ack at all
        cpu_address = 16'hFF30; cpu_rd_n = 1'b0;
        tick();
        bus_idle();
        n = 0;
`ifdef TINY16_MEM_CTRL_IO_TIMEOUT_EN
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!io_rd) break;
            n++;
            tick();
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_ready", cpu_ready, 1);
        chk("tmo_rdata", cpu_rdata, 16'hFFFF);
        chk("tmo_berr", bus_error, 1);
        tick();
`else
        for (int i = 0; i < 300; i++) begin
            #1;
            if (io_rd && !cpu_ready) n++;
            tick();
        end
        chk("notmo_still_waiting", n, 300);
        io_ack = 1'b1; io_rdata = 16'h0042;
        tick();
        io_ack = 1'b0;
        #1;
        chk("notmo_ready", cpu_ready, 1);
        chk("notmo_rdata", cpu_rdata, 16'h0042);
        chk("notmo_berr", bus_error, 0);
        tick();
`endif
        chk("final_idle_ready", cpu_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tiny16_mem_ctrl.md
Name: tiny16_mem_ctrl

Overview:
- Memory/bus controller directly downstream of the tiny16 core. It consumes the core's address, data_out, rd, wr bus and produces data_in and ready.
- Decodes three regions: ROM, RAM and 8-bit-addressed I/O.
- Inserts per-region wait states and runs a handshake with slow I/O peripherals.
- Flags illegal accesses on a sticky bus_error.

Parameters:
- ROM_TOP, 16'h0FFF, last ROM address; ROM region is 0x0000..ROM_TOP.
- IO_BASE, 16'hFF00, first I/O address; I/O region is IO_BASE..0xFFFF.
- ROM_WAIT, 1, ROM wait states (0..7).
- RAM_WAIT, 0, RAM wait states (0..7).
- IO_TIMEOUT, 255, I/O ack timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_address  in  16  core address
- cpu_wdata  in  16  core write data (core data_out)
- cpu_rd_n  in  1  read request, active-low
- cpu_wr  in  1  write request, active-high
- cpu_rdata  out  16  read data (core data_in)
- cpu_ready  out  1  transfer-complete / bus-free
- rom_addr  out  16  ROM address; rom_data  in  16  asynchronous-read ROM data
- ram_addr  out  16; ram_wdata  out  16; ram_we  out  1; ram_rdata  in  16  asynchronous-read RAM data
- io_addr  out  8; io_wdata  out  16; io_rd  out  1; io_wr  out  1; io_rdata  in  16; io_ack  in  1
- bus_error  out  1  sticky error flag

Behaviour:
- Request definitions:
  - req = !cpu_rd_n | cpu_wr.
  - If both are asserted, write wins and bus_error is set.
- Region decode:
  - addr <= ROM_TOP selects ROM.
  - addr >= IO_BASE selects IO.
  - Otherwise RAM.
- FSM states: IDLE, WAIT, IO_WAIT, DONE.
- IDLE:
  - No req: cpu_ready=1.
  - req to a memory region with wait count 0: cpu_ready=1 combinationally, the transfer completes at this edge, and the FSM stays in IDLE.
  - req to a memory region with wait count N>0: latch address, data and direction; load counter with N-1; cpu_ready=0; go to WAIT.
  - req to IO: latch; assert io_rd or io_wr from the next cycle; go to IO_WAIT.
- WAIT:
  - cpu_ready=0; counter decrements.
  - Counter reaching 0 moves to DONE.
  - Total ready-low time is exactly N cycles.
- IO_WAIT:
  - io_rd/io_wr held high; io_addr = latched address[7:0].
  - On io_ack=1: capture io_rdata into a register, drop the strobes on the same edge, and go to DONE.
- DONE:
  - cpu_ready=1 for exactly one cycle, then IDLE.
  - cpu_rdata comes from the latched source: memory data uses the latched address (combinational); I/O data uses the captured register.
- Writes:
  - ram_we is a single-cycle pulse in the completing cycle (zero-wait IDLE or DONE).
  - A ROM write drives no strobe, completes normally and sets bus_error.
- Read data: cpu_rdata is 16'h0000 when no read is completing.
- Request deasserted mid-transaction: the transaction still completes with no abort; read data is discarded and the write is still performed.
- Reset: reset=0 at any edge forces:
  - IDLE; cpu_ready=1; counter=0;
  - ram_we=0, io_rd=0, io_wr=0;
  - bus_error=0; io data register=0.
  - This includes reset mid-WAIT or mid-IO_WAIT; no strobe is issued afterwards.
- Address outputs: rom_addr/ram_addr follow cpu_address in IDLE and the latched address otherwise.

Optional Feature:
- Macro TINY16_MEM_CTRL_IO_TIMEOUT_EN.
- Defined:
  - IO_WAIT counts cycles.
  - After IO_TIMEOUT cycles without io_ack, strobes drop, read data is forced to 16'hFFFF, bus_error is set, and the FSM goes to DONE.
  - An io_ack arriving on the expiry cycle takes priority, giving normal completion.
- Undefined: IO_WAIT waits indefinitely and the timeout counter is absent.

Decomposition:
- Package tiny16_mem_pkg holds:
  - region enum (REG_ROM, REG_RAM, REG_IO);
  - FSM state enum;
  - default ROM_TOP/IO_BASE constants;
  - the 16'hFFFF timeout read value.
- One sub-module, tiny16_addr_decode: combinational address to region, parameterised by ROM_TOP/IO_BASE. Shared later by the DMA block.

Test Plan:
- RAM_WAIT=0, read 0x2000 with ram_rdata=16'hBEEF -> cpu_ready stays 1 and cpu_rdata=16'hBEEF in the same cycle.
- ROM_WAIT=3, read 0x0010 -> cpu_ready low exactly 3 cycles, then high 1 cycle with cpu_rdata=rom_data at 0x0010.
- Write 0x1234 to 0x2004 -> ram_we is a single 1-cycle pulse with ram_addr=0x2004 and ram_wdata=0x1234.
- Write to 0x0004 (ROM) -> no ram_we/io_wr, bus_error=1 and remains set until reset.
- I/O read at 0xFF05 with io_ack after 5 cycles and io_rdata=16'h00A5 -> io_addr=8'h05, io_rd high 5 cycles, then the DONE cycle gives cpu_rdata=16'h00A5.
- Reset low during IO_WAIT -> next cycle io_rd=0, cpu_ready=1, bus_error=0. With TINY16_MEM_CTRL_IO_TIMEOUT_EN and no ack -> after 255 cycles cpu_rdata=16'hFFFF and bus_error=1.
